// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: four-state (IDLE/DECODE/EXEC/WB) ALU controller owning 32x16 GPRs and one SGPR
//   clk, rst_n (async, active-low) | instr_valid/instr_ready/instr: instruction handshake
//   busy, done, illegal: status | wb_addr/wb_data: retiring write | sgpr_out | dbg_addr/dbg_data: GPR peek
module alu_exec_ctrl #(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [4:0]  wb_addr,
  output logic [15:0] wb_data,
  output logic [15:0] sgpr_out,
  input  logic [4:0]  dbg_addr,
  output logic [15:0] dbg_data
);
  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;
  state_t state, state_nx;
  logic [31:0] ir;
  logic [15:0] gpr [32];
  logic [15:0] sgpr, op_a, op_b, res, res_hi;
  logic [31:0] prod;
  logic [3:0]  cnt;
  logic [4:0]  opc, rdst, rsrc1, rsrc2;
  logic        imm, is_mul, is_ill, exec_last;
  assign opc       = ir[31:27];
  assign rdst      = ir[26:22];
  assign rsrc1     = ir[21:17];
  assign imm       = ir[16];
  assign rsrc2     = ir[15:11];
  assign is_mul    = opc == 5'd4;
  assign is_ill    = opc > 5'd11;
  assign exec_last = !is_mul || cnt == 4'(MUL_LAT - 1);
  assign prod      = {16'd0, op_a} * {16'd0, op_b};
  assign sgpr_out  = sgpr;
  assign dbg_data  = gpr[dbg_addr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (instr_valid && instr_ready) ? DECODE : IDLE;
      DECODE:  state_nx = EXEC;
      EXEC:    state_nx = exec_last ? WB : EXEC;
      default: state_nx = IDLE;
    endcase
  end
  // rst_n gates ready so nothing is offered while reset is still held
  always_comb begin
    instr_ready = state == IDLE && rst_n;
    busy        = state != IDLE;
    done        = state == WB;
    illegal     = state == WB && is_ill;
  end
  // op_a carries SGPR for movsgpr; mov/not pick isrc through op_b when imm is set
  always_comb begin
    res = '0;
    case (opc)
      5'd0:    res = op_a;
      5'd1:    res = imm ? op_b : op_a;
      5'd2:    res = op_a + op_b;
      5'd3:    res = op_a - op_b;
      5'd4:    res = prod[15:0];
      5'd5:    res = op_a | op_b;
      5'd6:    res = op_a & op_b;
      5'd7:    res = op_a ^ op_b;
      5'd8:    res = ~(op_a ^ op_b);
      5'd9:    res = ~(op_a & op_b);
      5'd10:   res = ~(op_a | op_b);
      5'd11:   res = ~(imm ? op_b : op_a);
      default: res = '0;
    endcase
  end
  // results are captured into wb_* at the end of EXEC and committed to GPR/SGPR on the edge leaving WB
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ir      <= '0;
      op_a    <= '0;
      op_b    <= '0;
      cnt     <= '0;
      res_hi  <= '0;
      sgpr    <= '0;
      wb_addr <= '0;
      wb_data <= '0;
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
    end else begin
      if (state == IDLE && instr_valid) ir <= instr;
      if (state == DECODE) begin
        op_a <= opc == 5'd0 ? sgpr : gpr[rsrc1];
        op_b <= imm ? ir[15:0] : gpr[rsrc2];
        cnt  <= '0;
      end
      if (state == EXEC) begin
        cnt <= cnt + 4'd1;
        if (exec_last) begin
          wb_addr <= rdst;
          wb_data <= res;
          res_hi  <= prod[31:16];
        end
      end
      if (state == WB && !is_ill) begin
        gpr[wb_addr] <= wb_data;
        if (is_mul) sgpr <= res_hi;
      end
    end
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl: directed and randomized checks of alu_exec_ctrl against an architectural register-file model
module tb_alu_exec_ctrl;
  localparam int LAT = 3;
  logic        clk = 0, rst_n = 0, instr_valid = 0;
  logic [31:0] instr = 0;
  logic [4:0]  dbg_addr = 0;
  logic        instr_ready, busy, done, illegal;
  logic [4:0]  wb_addr;
  logic [15:0] wb_data, sgpr_out, dbg_data;
  int total = 0, bad = 0;
  logic [15:0] gpr_m [32];
  logic [15:0] sgpr_m;

  alu_exec_ctrl #(.MUL_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .busy(busy), .done(done), .illegal(illegal), .wb_addr(wb_addr),
    .wb_data(wb_data), .sgpr_out(sgpr_out), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic dbg_check(input string tag, input logic [4:0] a, input logic [15:0] exp);
    dbg_addr = a;
    #1 check(tag, dbg_data, exp);
  endtask

  function automatic logic [31:0] mk(input logic [4:0] opc, input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic imm, input logic [15:0] lo);
    return {opc, rd, rs1, imm, lo};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) gpr_m[i] = '0;
    sgpr_m = '0;
  endtask

  task automatic issue(input logic [31:0] w, input bit keep = 0, input logic [31:0] nxt = 0);
    int t = 0, k = 0, lat;
    logic [4:0] opc, rd;
    logic [15:0] a, b, src, r, hi;
    longint p;
    bit ill;
    opc = w[31:27];
    rd  = w[26:22];
    a   = gpr_m[w[21:17]];
    b   = w[16] ? w[15:0] : gpr_m[w[15:11]];
    src = w[16] ? w[15:0] : a;
    ill = 0;
    hi  = sgpr_m;
    case (opc)
      5'd0:  r = sgpr_m;
      5'd1:  r = src;
      5'd2:  r = 16'((int'(a) + int'(b)) % 65536);
      5'd3:  r = 16'((int'(a) - int'(b) + 65536) % 65536);
      5'd4:  begin p = longint'(a) * longint'(b); r = 16'(p % 65536); hi = 16'(p / 65536); end
      5'd5:  r = a | b;
      5'd6:  r = a & b;
      5'd7:  r = a ^ b;
      5'd8:  r = ~(a ^ b);
      5'd9:  r = ~(a & b);
      5'd10: r = ~(a | b);
      5'd11: r = ~src;
      default: begin r = '0; ill = 1; end
    endcase
    lat = opc == 5'd4 ? LAT + 1 : 2;
    while (!instr_ready && t < 50) begin @(negedge clk); t++; end
    check("ready_idle", instr_ready, 1);
    instr = w;
    instr_valid = 1;
    @(negedge clk);
    if (keep) instr = nxt;
    else begin instr_valid = 0; instr = $urandom; end
    while (!done && k < 40) begin
      check("ready_low_busy", instr_ready, 0);
      check("busy", busy, 1);
      @(negedge clk);
      k++;
    end
    check("latency", k, lat);
    check("done", done, 1);
    check("illegal", illegal, ill);
    check("wb_addr", wb_addr, rd);
    check("wb_data", wb_data, r);
    if (!ill) begin
      gpr_m[rd] = r;
      if (opc == 5'd4) sgpr_m = hi;
    end
    @(negedge clk);
    check("done_pulse", done, 0);
    check("illegal_pulse", illegal, 0);
    check("busy_idle", busy, 0);
    check("wb_hold", wb_data, r);
    check("sgpr", sgpr_out, sgpr_m);
    dbg_check("gpr_dst", rd, gpr_m[rd]);
  endtask

  initial begin
    model_reset();
    #1;
    check("rst_ready", instr_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_illegal", illegal, 0);
    check("rst_wb_addr", wb_addr, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_sgpr", sgpr_out, 0);
    dbg_check("rst_gpr", 5'd9, 16'h0000);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    #1 check("ready_after_rst", instr_ready, 1);

    issue(mk(5'd1, 5'd1, 5'd0, 1'b1, 16'h0005));
    dbg_check("mov_r1", 5'd1, 16'h0005);
    issue(mk(5'd2, 5'd2, 5'd1, 1'b0, {5'd1, 11'd0}));
    dbg_check("add_r2", 5'd2, 16'h000A);
    issue(mk(5'd3, 5'd3, 5'd1, 1'b1, 16'h0006));
    dbg_check("sub_r3", 5'd3, 16'hFFFF);
    issue(mk(5'd8, 5'd4, 5'd1, 1'b1, 16'h00FF));
    dbg_check("xnor_r4", 5'd4, 16'hFF05);
    issue(mk(5'd1, 5'd1, 5'd0, 1'b1, 16'h1234));
    issue(mk(5'd4, 5'd4, 5'd1, 1'b1, 16'h0100));
    dbg_check("mul_r4", 5'd4, 16'h3400);
    check("mul_sgpr", sgpr_out, 16'h0012);
    issue(mk(5'd0, 5'd5, 5'd0, 1'b0, 16'h0000));
    dbg_check("movsgpr_r5", 5'd5, 16'h0012);
    issue(mk(5'd31, 5'd2, 5'd0, 1'b0, 16'h0000));
    dbg_check("illegal_r2", 5'd2, 16'h000A);
    check("illegal_sgpr", sgpr_out, 16'h0012);
    issue(mk(5'd3, 5'd1, 5'd1, 1'b0, {5'd1, 11'd0}));
    dbg_check("self_sub", 5'd1, 16'h0000);

    issue(mk(5'd2, 5'd7, 5'd5, 1'b1, 16'h0001), 1, mk(5'd7, 5'd8, 5'd7, 1'b1, 16'h00F0));
    issue(mk(5'd7, 5'd8, 5'd7, 1'b1, 16'h00F0));
    dbg_check("queued_r8", 5'd8, 16'h00E3);

    issue(mk(5'd1, 5'd1, 5'd0, 1'b1, 16'h0005));
    issue(mk(5'd1, 5'd6, 5'd0, 1'b1, 16'h0777));
    instr = mk(5'd2, 5'd6, 5'd1, 1'b1, 16'h0003);
    instr_valid = 1;
    @(negedge clk);
    instr_valid = 0;
    @(negedge clk);
    rst_n = 0;
    model_reset();
    #1;
    check("abort_busy", busy, 0);
    check("abort_ready", instr_ready, 0);
    check("abort_done", done, 0);
    dbg_check("abort_r6", 5'd6, 16'h0000);
    dbg_check("abort_r1", 5'd1, 16'h0000);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    #1 check("abort_ready_rel", instr_ready, 1);
    @(negedge clk);
    check("abort_idle", busy, 0);
    dbg_check("abort_r6_after", 5'd6, 16'h0000);

    for (int n = 0; n < 300; n++) begin
      logic [4:0] opc;
      opc = 5'($urandom_range(0, 13));
      if (opc > 5'd11) opc = 5'($urandom_range(12, 31));
      issue(mk(opc, 5'($urandom), 5'($urandom), 1'($urandom), 16'($urandom)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
